core_fetch_port: RTL and testbench

CORE_FETCH_PORT -- requirements
Module: core_fetch_port

---
 rtl/core_fetch_port.sv | 82 ++++++++
 tb/tb_core_fetch_port.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/core_fetch_port.sv
// core_fetch_port: single-outstanding Avalon-MM instruction fetch port with flush/stale handling and bus timeout.
// Optional CORE_FETCH_PORT_STATS_EN adds stat_issued/stat_dropped counters.
module core_fetch_port #(
  parameter int unsigned WAIT_LIMIT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch,
  input  logic [29:0] addr,
  input  logic        flush,
  output logic        fetched,
  output logic [31:0] fetch_data,
  output logic [31:0] avl_address,
  output logic        avl_read,
  input  logic        avl_waitrequest,
  input  logic [31:0] avl_readdata,
  input  logic        avl_readdatavalid,
  output logic        bus_timeout
`ifdef CORE_FETCH_PORT_STATS_EN
  ,
  output logic [31:0] stat_issued,
  output logic [31:0] stat_dropped
`endif
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;
  state_t state, state_n;
  logic [29:0] req_addr;
  logic [31:0] cnt, cnt_n;
  logic flush_seen, rdy, start, accept, deliver, discard, busy, busy_n;
  assign avl_read = state == REQ;
  assign avl_address = {req_addr, 2'b00};
  always_comb begin
    state_n = state;
    start = state == IDLE && rdy && fetch && !flush;
    accept = state == REQ && !avl_waitrequest;
    deliver = state == WAIT && avl_readdatavalid && !flush;
    discard = avl_readdatavalid && (state == DROP || (state == WAIT && flush));
    case (state)
      IDLE: state_n = start ? REQ : IDLE;
      REQ:  state_n = !accept ? REQ : (flush || flush_seen) ? DROP : WAIT;
      WAIT: state_n = avl_readdatavalid ? IDLE : flush ? DROP : WAIT;
      DROP: state_n = avl_readdatavalid ? IDLE : DROP;
    endcase
    busy = state == WAIT || state == DROP;
    busy_n = state_n == WAIT || state_n == DROP;
    // cnt is the 1-based index of the current WAIT/DROP cycle, saturating at WAIT_LIMIT
    cnt_n = !busy_n ? 32'd0 : !busy ? 32'd1 : (cnt < WAIT_LIMIT) ? cnt + 32'd1 : cnt;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      req_addr <= '0;
      flush_seen <= 1'b0;
      rdy <= 1'b0;
      cnt <= '0;
      fetched <= 1'b0;
      fetch_data <= '0;
      bus_timeout <= 1'b0;
    end else begin
      state <= state_n;
      rdy <= 1'b1;
      req_addr <= start ? addr : req_addr;
      flush_seen <= state == REQ && !accept && (flush_seen || flush);
      cnt <= cnt_n;
      fetched <= deliver;
      fetch_data <= deliver ? avl_readdata : fetch_data;
      bus_timeout <= bus_timeout || (WAIT_LIMIT != 0 && cnt_n >= WAIT_LIMIT);
    end
`ifdef CORE_FETCH_PORT_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stat_issued <= '0;
      stat_dropped <= '0;
    end else begin
      stat_issued <= accept ? stat_issued + 32'd1 : stat_issued;
      stat_dropped <= discard ? stat_dropped + 32'd1 : stat_dropped;
    end
`else
  logic unused;
  assign unused = discard;
`endif
endmodule

// File: tb/tb_core_fetch_port.sv
// tb_core_fetch_port: directed + randomized bench with a transaction-level reference model.
module tb_core_fetch_port;
  localparam int unsigned LIM = 8;
  logic clk = 1'b0, rst_n, fetch, flush, avl_waitrequest, avl_readdatavalid;
  logic [29:0] addr;
  logic [31:0] avl_readdata, fetch_data, avl_address;
  logic fetched, avl_read, bus_timeout;
  int cmp_n = 0, err_n = 0;
`ifdef CORE_FETCH_PORT_STATS_EN
  logic [31:0] stat_issued, stat_dropped;
`endif
  core_fetch_port #(.WAIT_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n), .fetch(fetch), .addr(addr), .flush(flush),
    .fetched(fetched), .fetch_data(fetch_data), .avl_address(avl_address),
    .avl_read(avl_read), .avl_waitrequest(avl_waitrequest), .avl_readdata(avl_readdata),
    .avl_readdatavalid(avl_readdatavalid), .bus_timeout(bus_timeout)
`ifdef CORE_FETCH_PORT_STATS_EN
    , .stat_issued(stat_issued), .stat_dropped(stat_dropped)
`endif
  );
  always #5 clk = ~clk;
  // transaction-level model: open transaction, accepted or not, stale or not
  bit m_txn, m_acc, m_stale, m_rdy, m_fetched, m_tmo;
  logic [29:0] m_addr;
  logic [31:0] m_data, m_issued, m_dropped;
  int m_waited;
  task automatic m_reset();
    m_txn = 0; m_acc = 0; m_stale = 0; m_rdy = 0; m_fetched = 0; m_tmo = 0;
    m_addr = '0; m_data = '0; m_issued = '0; m_dropped = '0; m_waited = 0;
  endtask
  initial m_reset();
  always @(posedge clk) begin
    if (!rst_n) m_reset();
    else begin
      m_fetched = 0;
      if (!m_txn) begin
        if (m_rdy && fetch && !flush) begin
          m_txn = 1; m_acc = 0; m_stale = 0; m_addr = addr;
        end
      end else if (!m_acc) begin
        m_stale |= flush;
        if (!avl_waitrequest) begin
          m_acc = 1; m_issued++; m_waited = 1;
          if (LIM != 0 && m_waited >= LIM) m_tmo = 1;
        end
      end else begin
        m_stale |= flush;
        if (avl_readdatavalid) begin
          if (m_stale) m_dropped++;
          else begin m_fetched = 1; m_data = avl_readdata; end
          m_txn = 0;
        end else begin
          m_waited++;
          if (LIM != 0 && m_waited >= LIM) m_tmo = 1;
        end
      end
      m_rdy = 1;
    end
  end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    cmp_n++;
    if (a !== e) begin
      err_n++;
      $display("FAIL %s @%0t: got %h expected %h", n, $time, a, e);
    end
  endtask
  always @(negedge clk) begin
    if (!rst_n) m_reset();
    chk("avl_read", 32'(avl_read), 32'(m_txn && !m_acc));
    chk("avl_address", avl_address, {m_addr, 2'b00});
    chk("fetched", 32'(fetched), 32'(m_fetched));
    chk("fetch_data", fetch_data, m_data);
    chk("bus_timeout", 32'(bus_timeout), 32'(m_tmo));
`ifdef CORE_FETCH_PORT_STATS_EN
    chk("stat_issued", stat_issued, m_issued);
    chk("stat_dropped", stat_dropped, m_dropped);
`endif
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic zeros(input string n);
    chk({n, ".read"}, 32'(avl_read), 0);
    chk({n, ".fetched"}, 32'(fetched), 0);
    chk({n, ".data"}, fetch_data, 0);
    chk({n, ".addr"}, avl_address, 0);
    chk({n, ".tmo"}, 32'(bus_timeout), 0);
  endtask
  initial begin
    rst_n = 1; fetch = 0; addr = '0; flush = 0; avl_waitrequest = 0;
    avl_readdatavalid = 0; avl_readdata = '0;
    #2 rst_n = 0;
    cyc(); cyc();
    zeros("reset");
    rst_n = 1; fetch = 1; addr = 30'h100;
    cyc();
    chk("first_edge_no_req", 32'(avl_read), 0);
    cyc();
    chk("basic.read", 32'(avl_read), 1);
    chk("basic.addr", avl_address, 32'h400);
    fetch = 0;
    cyc();
    chk("basic.accepted", 32'(avl_read), 0);
    cyc();
    avl_readdatavalid = 1; avl_readdata = 32'hE3A00001;
    chk("basic.no_early", 32'(fetched), 0);
    cyc();
    avl_readdatavalid = 0;
    chk("basic.fetched", 32'(fetched), 1);
    chk("basic.data", fetch_data, 32'hE3A00001);
    cyc();
    chk("basic.single_pulse", 32'(fetched), 0);
    chk("basic.hold", fetch_data, 32'hE3A00001);
    fetch = 1; addr = 30'h100; avl_waitrequest = 1;
    cyc();
    fetch = 0; addr = 30'h200;
    for (int i = 0; i < 5; i++) begin
      chk("stall.read", 32'(avl_read), 1);
      chk("stall.addr", avl_address, 32'h400);
      cyc();
    end
    avl_waitrequest = 0;
    chk("stall.read6", 32'(avl_read), 1);
    cyc();
    chk("stall.accepted", 32'(avl_read), 0);
    avl_readdatavalid = 1; avl_readdata = 32'h12345678;
    cyc();
    avl_readdatavalid = 0;
    chk("stall.fetched", 32'(fetched), 1);
    chk("stall.data", fetch_data, 32'h12345678);
    chk("no_req_on_pulse", 32'(avl_read), 0);
    fetch = 1; addr = 30'h300;
    cyc();
    chk("req_after_pulse", 32'(avl_read), 1);
    avl_waitrequest = 1; flush = 1; addr = 30'h200; fetch = 0;
    cyc();
    flush = 0; avl_waitrequest = 0;
    cyc();
    avl_readdatavalid = 1; avl_readdata = 32'hDEADBEEF;
    cyc();
    avl_readdatavalid = 0;
    chk("flushreq.no_pulse", 32'(fetched), 0);
    chk("flushreq.data_kept", fetch_data, 32'h12345678);
    fetch = 1;
    cyc();
    chk("flushreq.new_addr", avl_address, 32'h800);
    fetch = 0;
    cyc();
    avl_readdatavalid = 1; flush = 1; avl_readdata = 32'h00000BAD;
    cyc();
    avl_readdatavalid = 0; flush = 0;
    chk("flushwait.no_pulse", 32'(fetched), 0);
    fetch = 1; addr = 30'h040;
    cyc();
    chk("flushwait.next_req", 32'(avl_read), 1);
    chk("flushwait.next_addr", avl_address, 32'h100);
    fetch = 0;
    cyc();
    avl_readdatavalid = 1; avl_readdata = 32'hCAFEF00D;
    cyc();
    avl_readdatavalid = 0;
    chk("flushwait.fetched", 32'(fetched), 1);
    chk("flushwait.data", fetch_data, 32'hCAFEF00D);
    fetch = 1; addr = 30'h10;
    cyc();
    fetch = 0;
    cyc();
    for (int k = 1; k <= 10; k++) begin
      chk($sformatf("timeout.wait%0d", k), 32'(bus_timeout), 32'(k >= 8));
      cyc();
    end
    avl_readdatavalid = 1; avl_readdata = 32'h000055AA;
    cyc();
    avl_readdatavalid = 0;
    chk("timeout.late_fetched", 32'(fetched), 1);
    chk("timeout.late_data", fetch_data, 32'h000055AA);
    chk("timeout.sticky", 32'(bus_timeout), 1);
    fetch = 1; addr = 30'h3FF;
    cyc();
    fetch = 0;
    cyc();
    cyc();
    rst_n = 0;
    #1;
    zeros("async_reset");
    cyc();
    rst_n = 1; avl_readdatavalid = 1; avl_readdata = 32'h0BADF00D;
    cyc();
    zeros("stale_after_reset1");
    cyc();
    avl_readdatavalid = 0;
    zeros("stale_after_reset2");
    for (int i = 0; i < 3000; i++) begin
      fetch = $urandom_range(0, 9) < 6;
      addr = 30'($urandom);
      flush = $urandom_range(0, 15) == 0;
      avl_waitrequest = $urandom_range(0, 2) == 0;
      avl_readdatavalid = $urandom_range(0, 3) == 0;
      avl_readdata = $urandom;
      rst_n = $urandom_range(0, 299) != 0;
      cyc();
    end
    rst_n = 1;
    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end
endmodule
